// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one single-ported synchronous memory between the instruction-fetch
// port and the MEM-stage data port. One access is in flight at a time: the
// winner is latched in IDLE, strobed to memory in ISSUE, waits out the fixed
// read latency in WAIT, and gets a one-cycle ready pulse in DONE. The data port
// normally has priority. A fairness counter forces a fetch grant after
// FAIR_LIMIT consecutive data grants made while fetch was waiting.

module dmem_port_arbiter #(
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned FAIR_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   // instruction-fetch port
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ready,
   // MEM-stage data port
   input  logic [1:0]  d_ctrl,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ready,
   // pipeline stall requests
   output logic        stall_if,
   output logic        stall_mem,
   // memory side
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
   localparam int unsigned FAIR_W = (FAIR_LIMIT > 1) ? $clog2(FAIR_LIMIT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic                d_req;
   logic                d_elig;
   logic                i_elig;
   logic                fair_hit;
   logic                fetch_win;

   logic                grant_c;       // a grant is made this cycle (IDLE only)
   logic                grant_data_c;  // that grant goes to the data port
   logic                capture_c;     // mem_rdata is valid this cycle

   logic                grant_data;    // owner of the access in flight: 1 = data
   logic [LAT_W-1:0]    lat_cnt;
   logic [FAIR_W-1:0]   fair_cnt;

   // A 2'b11 command is a store; any nonzero command is a request.
   assign d_req = |d_ctrl;

   // Stall each pipeline stage while its request is outstanding.
   assign stall_mem = d_req & ~d_ready;
   assign stall_if  = i_req & ~i_ready;

   // Eligibility and priority: data first unless fetch has waited too long.
   always_comb begin
      d_elig    = d_req & ~d_ready;
      i_elig    = i_req & ~i_ready;
      fair_hit  = (fair_cnt == FAIR_W'(FAIR_LIMIT));
      fetch_win = i_elig & (~d_elig | fair_hit);
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-cycle control strobes.
   always_comb begin
      state_nxt    = state;
      grant_c      = 1'b0;
      grant_data_c = 1'b0;
      capture_c    = 1'b0;
      case (state)
         IDLE: begin
            if (d_elig || i_elig) begin
               grant_c      = 1'b1;
               grant_data_c = ~fetch_win;
               state_nxt    = ISSUE;
            end
         end
         ISSUE: begin
            // mem_we holds the latched direction of this access
            state_nxt = mem_we ? DONE : WAIT;
         end
         WAIT: begin
            if (lat_cnt == LAT_W'(1)) begin
               capture_c = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Latch owner, address, direction and store data of the granted request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_data <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_we     <= 1'b0;
      end else if (grant_c) begin
         grant_data <= grant_data_c;
         if (grant_data_c) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_we    <= d_ctrl[0];
         end else begin
            mem_addr  <= i_addr;
            mem_we    <= 1'b0;
         end
      end
   end

   // Memory strobe: high for exactly the ISSUE cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_en <= 1'b0;
      end else begin
         mem_en <= (state_nxt == ISSUE);
      end
   end

   // Read latency countdown: loaded in ISSUE, reaches 1 when mem_rdata is valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_cnt <= '0;
      end else if (state == ISSUE) begin
         lat_cnt <= LAT_W'(MEM_LAT);
      end else if (state == WAIT) begin
         lat_cnt <= lat_cnt - LAT_W'(1);
      end
   end

   // Fairness: count data grants that made a waiting fetch lose.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fair_cnt <= '0;
      end else if (state == IDLE) begin
         if (grant_c && !grant_data_c) begin
            fair_cnt <= '0;
         end else if (!i_req) begin
            fair_cnt <= '0;
         end else if (grant_c && !fair_hit) begin
            fair_cnt <= fair_cnt + FAIR_W'(1);
         end
      end
   end

   // Capture read data into the owner's register only; the other holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_rdata <= '0;
         i_rdata <= '0;
      end else if (capture_c) begin
         if (grant_data) begin
            d_rdata <= mem_rdata;
         end else begin
            i_rdata <= mem_rdata;
         end
      end
   end

   // One-cycle ready pulse to the owner while in DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_ready <= 1'b0;
         i_ready <= 1'b0;
      end else begin
         d_ready <= (state_nxt == DONE) &&  grant_data;
         i_ready <= (state_nxt == DONE) && !grant_data;
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Two instances: A with MEM_LAT=1 for most scenarios, B with MEM_LAT=3 for
// the longer-latency and 2'b11 cases. A bench-side memory model answers both.
// Expected read data is queued when a request is presented and compared when
// the matching ready pulse appears.

module tb_dmem_port_arbiter;

   localparam int unsigned LAT_A = 1;
   localparam int unsigned LAT_B = 3;
   localparam int unsigned FAIR  = 4;

   typedef struct packed {
      logic        rd;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        reset;

   // instance A
   logic        i_req, i_ready, d_ready, stall_if, stall_mem, mem_en, mem_we;
   logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  d_ctrl;

   // instance B
   logic        i_req_b, i_ready_b, d_ready_b, stall_if_b, stall_mem_b, mem_en_b, mem_we_b;
   logic [31:0] i_addr_b, i_rdata_b, d_addr_b, d_wdata_b, d_rdata_b;
   logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;
   logic [1:0]  d_ctrl_b;

   int          n_checks = 0;
   int          n_errors = 0;
   int unsigned cyc = 0;

   exp_t        dq_a[$];
   exp_t        iq_a[$];
   exp_t        dq_b[$];
   exp_t        mon_a;
   exp_t        mon_b;
   logic [31:0] last_d_a = '0;
   logic [31:0] last_i_a = '0;
   logic [31:0] last_d_b = '0;

   logic [31:0] mem [logic [31:0]];
   logic [31:0] pipe_a;
   logic [31:0] pipe_b [3];

   dmem_port_arbiter #(.MEM_LAT(LAT_A), .FAIR_LIMIT(FAIR)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
      .d_ctrl(d_ctrl), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
      .stall_if(stall_if), .stall_mem(stall_mem),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   dmem_port_arbiter #(.MEM_LAT(LAT_B), .FAIR_LIMIT(FAIR)) u_dut_b (
      .clk(clk), .reset(reset),
      .i_req(i_req_b), .i_addr(i_addr_b), .i_rdata(i_rdata_b), .i_ready(i_ready_b),
      .d_ctrl(d_ctrl_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b), .d_rdata(d_rdata_b), .d_ready(d_ready_b),
      .stall_if(stall_if_b), .stall_mem(stall_mem_b),
      .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] model_read(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return a ^ 32'h5A5A_5A5A;
   endfunction

   // Memory for A: data valid one cycle after the strobe, junk otherwise.
   always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
      pipe_a <= (mem_en && !mem_we) ? model_read(mem_addr) : (32'hBAD0_0000 ^ cyc);
   end
   assign mem_rdata = pipe_a;

   // Memory for B: three-stage read pipeline.
   always @(posedge clk) begin
      if (mem_en_b && mem_we_b) mem[mem_addr_b] = mem_wdata_b;
      pipe_b[0] <= (mem_en_b && !mem_we_b) ? model_read(mem_addr_b) : (32'hBAD1_0000 ^ cyc);
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign mem_rdata_b = pipe_b[2];

   // Scoreboard for A: pop on each ready, check owner data and that the other port held.
   always @(negedge clk) begin
      if (reset) begin
         last_d_a = '0;
         last_i_a = '0;
      end else begin
         if (d_ready) begin
            n_checks++;
            if (dq_a.size() == 0) begin
               n_errors++;
               $display("FAIL a_d_ready_unexpected: d_ready=1 with nothing pending at cycle %0d", cyc);
            end else begin
               mon_a = dq_a.pop_front();
               if (mon_a.rd) last_d_a = mon_a.data;
               if (d_rdata !== last_d_a) begin
                  n_errors++;
                  $display("FAIL a_d_rdata: got %h, want %h", d_rdata, last_d_a);
               end
            end
            n_checks++;
            if (i_rdata !== last_i_a) begin
               n_errors++;
               $display("FAIL a_i_rdata_hold: got %h, want %h", i_rdata, last_i_a);
            end
         end
         if (i_ready) begin
            n_checks++;
            if (iq_a.size() == 0) begin
               n_errors++;
               $display("FAIL a_i_ready_unexpected: i_ready=1 with nothing pending at cycle %0d", cyc);
            end else begin
               mon_a = iq_a.pop_front();
               last_i_a = mon_a.data;
               if (i_rdata !== last_i_a) begin
                  n_errors++;
                  $display("FAIL a_i_rdata: got %h, want %h", i_rdata, last_i_a);
               end
            end
            n_checks++;
            if (d_rdata !== last_d_a) begin
               n_errors++;
               $display("FAIL a_d_rdata_hold: got %h, want %h", d_rdata, last_d_a);
            end
         end
      end
   end

   // Scoreboard for B data port.
   always @(negedge clk) begin
      if (reset) begin
         last_d_b = '0;
      end else if (d_ready_b) begin
         n_checks++;
         if (dq_b.size() == 0) begin
            n_errors++;
            $display("FAIL b_d_ready_unexpected: d_ready=1 with nothing pending at cycle %0d", cyc);
         end else begin
            mon_b = dq_b.pop_front();
            if (mon_b.rd) last_d_b = mon_b.data;
            if (d_rdata_b !== last_d_b) begin
               n_errors++;
               $display("FAIL b_d_rdata: got %h, want %h", d_rdata_b, last_d_b);
            end
         end
      end
   end

   // One data access on instance A (sel=0) or B (sel=1), checking strobe, stall and latency.
   task automatic d_access(input bit sel, input logic [1:0] ctrl, input logic [31:0] addr,
                           input logic [31:0] wdata, input int exp_lat, input string name);
      exp_t        e;
      int          cnt;
      logic        rdy, en, we, smem;
      logic [31:0] ma, mw;
      logic        wr;
      wr = ctrl[0];
      @(negedge clk);
      e.rd   = ~wr;
      e.data = wr ? 32'h0 : model_read(addr);
      if (sel) begin
         dq_b.push_back(e);
         d_ctrl_b = ctrl; d_addr_b = addr; d_wdata_b = wdata;
      end else begin
         dq_a.push_back(e);
         d_ctrl = ctrl; d_addr = addr; d_wdata = wdata;
      end
      cnt = 0;
      rdy = 1'b0;
      while (!rdy && cnt < 40) begin
         @(negedge clk);
         cnt++;
         rdy  = sel ? d_ready_b   : d_ready;
         en   = sel ? mem_en_b    : mem_en;
         we   = sel ? mem_we_b    : mem_we;
         smem = sel ? stall_mem_b : stall_mem;
         ma   = sel ? mem_addr_b  : mem_addr;
         mw   = sel ? mem_wdata_b : mem_wdata;
         n_checks++;
         if (cnt == 1) begin
            if (en !== 1'b1 || we !== wr || ma !== addr || (wr && mw !== wdata)) begin
               n_errors++;
               $display("FAIL %s_issue: en=%b we=%b addr=%h wdata=%h, want en=1 we=%b addr=%h wdata=%h",
                        name, en, we, ma, mw, wr, addr, wdata);
            end
         end else if (en !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_mem_en_extra: mem_en=%b at cycle %0d after request, want 0", name, en, cnt);
         end
         n_checks++;
         if (smem !== ~rdy) begin
            n_errors++;
            $display("FAIL %s_stall_mem: got %b, want %b at cycle %0d", name, smem, ~rdy, cnt);
         end
      end
      n_checks++;
      if (!rdy || cnt != exp_lat) begin
         n_errors++;
         $display("FAIL %s_latency: ready after %0d cycles (seen=%b), want %0d", name, cnt, rdy, exp_lat);
      end
      if (sel) d_ctrl_b = 2'b00;
      else     d_ctrl   = 2'b00;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({mem_en, mem_we, i_ready, d_ready, mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: en=%b we=%b ir=%b dr=%b addr=%h wd=%h ird=%h drd=%h, want all 0",
                  mem_en, mem_we, i_ready, d_ready, mem_addr, mem_wdata, i_rdata, d_rdata);
      end
      n_checks++;
      if ({mem_en_b, d_ready_b, i_ready_b, d_rdata_b} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs_b: en=%b dr=%b ir=%b drd=%h, want all 0",
                  mem_en_b, d_ready_b, i_ready_b, d_rdata_b);
      end
      i_req = 1'b1; d_ctrl = 2'b10;
      #1;
      n_checks++;
      if (stall_if !== 1'b1 || stall_mem !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_stalls: stall_if=%b stall_mem=%b, want 1 1", stall_if, stall_mem);
      end
      i_req = 1'b0; d_ctrl = 2'b00;
      #1;
      reset = 1'b0;
   endtask

   task automatic test_single_load;
      mem[32'h100] = 32'hDEAD_BEEF;
      d_access(1'b0, 2'b10, 32'h100, 32'h0, LAT_A + 2, "load");
   endtask

   task automatic test_single_store;
      d_access(1'b0, 2'b01, 32'h200, 32'h1234_5678, 2, "store");
      n_checks++;
      if (mem[32'h200] !== 32'h1234_5678) begin
         n_errors++;
         $display("FAIL store_commit: memory holds %h, want 12345678", mem[32'h200]);
      end
   endtask

   task automatic test_simultaneous;
      exp_t e;
      int   cnt;
      int   d_at;
      int   i_at;
      @(negedge clk);
      e.rd = 1'b1;
      e.data = model_read(32'h104); dq_a.push_back(e);
      e.data = model_read(32'h300); iq_a.push_back(e);
      d_ctrl = 2'b10; d_addr = 32'h104;
      i_req  = 1'b1;  i_addr = 32'h300;
      cnt = 0; d_at = -1; i_at = -1;
      while (i_at < 0 && cnt < 40) begin
         @(negedge clk);
         cnt++;
         n_checks++;
         if (stall_if !== ~i_ready) begin
            n_errors++;
            $display("FAIL sim_stall_if: got %b, want %b at cycle %0d", stall_if, ~i_ready, cnt);
         end
         if (d_ready) begin d_at = cnt; d_ctrl = 2'b00; end
         if (i_ready) begin i_at = cnt; i_req = 1'b0; end
      end
      n_checks++;
      if (d_at != int'(LAT_A + 2)) begin
         n_errors++;
         $display("FAIL sim_data_first: d_ready at %0d, want %0d", d_at, LAT_A + 2);
      end
      n_checks++;
      if (i_at != int'(2 * (LAT_A + 2) + 1)) begin
         n_errors++;
         $display("FAIL sim_fetch_latency: i_ready at %0d, want %0d", i_at, 2 * (LAT_A + 2) + 1);
      end
      i_req = 1'b0;
      d_ctrl = 2'b00;
   endtask

   task automatic test_fairness;
      exp_t        e;
      logic [31:0] d_nxt, i_nxt;
      int          nd, ni, ng, cnt;
      bit          kind [10];
      bit          exp_kind [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      @(negedge clk);
      e.rd = 1'b1;
      d_nxt = 32'h500; i_nxt = 32'h400;
      e.data = model_read(d_nxt); dq_a.push_back(e);
      e.data = model_read(i_nxt); iq_a.push_back(e);
      d_ctrl = 2'b10; d_addr = d_nxt;
      i_req  = 1'b1;  i_addr = i_nxt;
      nd = 0; ni = 0; ng = 0; cnt = 0;
      while ((nd < 8 || ni < 2) && cnt < 200) begin
         @(negedge clk);
         cnt++;
         if (mem_en) begin
            if (ng < 10) kind[ng] = (mem_addr >= 32'h500);
            ng++;
         end
         if (d_ready) begin
            nd++;
            if (nd < 8) begin
               d_nxt = d_nxt + 32'd4;
               e.data = model_read(d_nxt); dq_a.push_back(e);
               d_addr = d_nxt;
            end else begin
               d_ctrl = 2'b00;
            end
         end
         if (i_ready) begin
            ni++;
            if (ni < 2) begin
               i_nxt = i_nxt + 32'd4;
               e.data = model_read(i_nxt); iq_a.push_back(e);
               i_addr = i_nxt;
            end else begin
               i_req = 1'b0;
            end
         end
      end
      d_ctrl = 2'b00;
      i_req  = 1'b0;
      n_checks++;
      if (ng != 10 || nd != 8 || ni != 2) begin
         n_errors++;
         $display("FAIL fair_counts: grants=%0d data=%0d fetch=%0d, want 10 8 2", ng, nd, ni);
      end
      for (int k = 0; k < 10; k++) begin
         n_checks++;
         if (kind[k] !== exp_kind[k]) begin
            n_errors++;
            $display("FAIL fair_grant_%0d: data=%b, want data=%b", k, kind[k], exp_kind[k]);
         end
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   cnt;
      int   first_at;
      int   second_at;
      @(negedge clk);
      e.rd = 1'b1;
      e.data = model_read(32'h700); dq_a.push_back(e);
      d_ctrl = 2'b10; d_addr = 32'h700;
      cnt = 0; first_at = -1; second_at = -1;
      while (second_at < 0 && cnt < 40) begin
         @(negedge clk);
         cnt++;
         if (d_ready) begin
            if (first_at < 0) begin
               first_at = cnt;
               e.data = model_read(32'h704); dq_a.push_back(e);
               d_addr = 32'h704;
            end else begin
               second_at = cnt;
               d_ctrl = 2'b00;
            end
         end
      end
      d_ctrl = 2'b00;
      n_checks++;
      if (first_at != int'(LAT_A + 2) || second_at - first_at != int'(LAT_A + 3)) begin
         n_errors++;
         $display("FAIL b2b_spacing: readies at %0d and %0d, want %0d and %0d",
                  first_at, second_at, LAT_A + 2, 2 * LAT_A + 5);
      end
   endtask

   task automatic test_lat3;
      d_access(1'b1, 2'b10, 32'h800, 32'h0, LAT_B + 2, "b_load");
      d_access(1'b1, 2'b11, 32'h900, 32'hCAFE_F00D, 2, "b_rw_as_write");
      n_checks++;
      if (mem[32'h900] !== 32'hCAFE_F00D) begin
         n_errors++;
         $display("FAIL b_rw_commit: memory holds %h, want cafef00d", mem[32'h900]);
      end
   endtask

   task automatic test_reset_mid_read;
      @(negedge clk);
      d_ctrl = 2'b10; d_addr = 32'h600;
      @(negedge clk);
      n_checks++;
      if (mem_en !== 1'b1) begin
         n_errors++;
         $display("FAIL rst_mid_issue: mem_en=%b, want 1", mem_en);
      end
      @(negedge clk);
      reset = 1'b1;
      d_ctrl = 2'b00;
      #1;
      n_checks++;
      if ({mem_en, mem_we, i_ready, d_ready, mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
         n_errors++;
         $display("FAIL rst_mid_outputs: en=%b we=%b ir=%b dr=%b addr=%h wd=%h ird=%h drd=%h, want all 0",
                  mem_en, mem_we, i_ready, d_ready, mem_addr, mem_wdata, i_rdata, d_rdata);
      end
      repeat (2) @(negedge clk);
      #1;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_checks++;
         if (d_ready !== 1'b0 || i_ready !== 1'b0 || mem_en !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_mid_quiet: d_ready=%b i_ready=%b mem_en=%b, want 0 0 0", d_ready, i_ready, mem_en);
         end
      end
      d_access(1'b0, 2'b10, 32'h604, 32'h0, LAT_A + 2, "post_reset_load");
   endtask

   initial begin
      reset = 1'b1;
      i_req = 1'b0;   i_addr = '0;   d_ctrl = 2'b00;   d_addr = '0;   d_wdata = '0;
      i_req_b = 1'b0; i_addr_b = '0; d_ctrl_b = 2'b00; d_addr_b = '0; d_wdata_b = '0;
      test_reset();
      test_single_load();
      test_simultaneous();
      test_single_store();
      test_fairness();
      test_back_to_back();
      test_lat3();
      test_reset_mid_read();
      repeat (3) @(negedge clk);
      n_checks++;
      if (dq_a.size() != 0 || iq_a.size() != 0 || dq_b.size() != 0) begin
         n_errors++;
         $display("FAIL leftover_expectations: a_d=%0d a_i=%0d b_d=%0d, want 0 0 0",
                  dq_a.size(), iq_a.size(), dq_b.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares one single-ported synchronous memory between the instruction-fetch port and the MEM-stage data port.
- Grants one access at a time and sequences the fixed memory read latency.
- Returns read data and a one-cycle ready pulse to the granted requester; drives stall requests to the pipeline.
- Data port has priority; a fairness counter prevents fetch starvation.

Parameters:
- MEM_LAT, 1, memory read latency in cycles (≥1): mem_rdata valid MEM_LAT cycles after the cycle mem_en is high.
- FAIR_LIMIT, 4, consecutive data grants while fetch is waiting before fetch is forced to win (≥1).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr until i_ready
- i_addr  in  32  fetch address
- i_rdata  out  32  fetch read data, valid while i_ready=1
- i_ready  out  1  one-cycle pulse: fetch complete
- d_ctrl  in  2  {read, write}; 2'b00 = no request; 2'b11 treated as write
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid while d_ready=1
- d_ready  out  1  one-cycle pulse: data access complete
- stall_if  out  1  fetch stall request
- stall_mem  out  1  MEM-stage stall request
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

Behaviour:
- Reset: state IDLE; fair counter 0. All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, i_rdata, i_ready, d_rdata, d_ready. stall_* follow the combinational rule below.
- Reset mid-operation: access is abandoned with no ready pulse. A write strobe already issued may have committed.
- States: IDLE, ISSUE, WAIT, DONE.
- Eligibility: d_req = |d_ctrl. A port whose ready is high this cycle is not eligible.
- IDLE, arbitration:
  - Data wins if d_req, unless i_req and fair_cnt == FAIR_LIMIT; then fetch wins.
  - Grant, address, write data and we (d_ctrl[0] for data, 0 for fetch) are latched. Next state ISSUE.
  - No request: stay IDLE.
- fair_cnt:
  - Increments on each data grant made while i_req=1, saturating at FAIR_LIMIT.
  - Clears on any fetch grant, or on any IDLE cycle with i_req=0.
- ISSUE: mem_en=1 for exactly this cycle, driving the latched mem_addr/mem_we/mem_wdata.
  - Write: next state DONE.
  - Read: load latency counter with MEM_LAT; next state WAIT.
- WAIT: counter decrements each cycle. In the cycle the counter reaches 1 (that is, MEM_LAT cycles after ISSUE), mem_rdata is captured into the granted port's rdata register. Next state DONE.
- DONE: granted port's ready=1 for exactly one cycle; rdata held. The other port's rdata register is unchanged. Next state IDLE.
- Latency from request first seen in IDLE:
  - write: ready 2 cycles later
  - read: ready MEM_LAT+2 cycles later
  - back-to-back accesses: one IDLE arbitration cycle between them
- mem_addr/mem_wdata/mem_we keep their last value outside ISSUE; only mem_en qualifies them.
- Stalls (combinational):
  - stall_mem = d_req & ~d_ready
  - stall_if = i_req & ~i_ready
- Requester must hold request and operands stable until its ready. Changes before ready are not observed after latching in IDLE.
- Simultaneous requests with fair_cnt < FAIR_LIMIT: data wins; the fetch request stays pending, stall_if=1.
- Address/data are 32-bit pass-through; no alignment checks or byte enables.

Test Plan:
- Reset mid-read: assert reset during WAIT -> all outputs 0 immediately; no ready pulse; IDLE afterwards; next d_ctrl=2'b10 completes normally.
- Single load, MEM_LAT=1:
  - d_ctrl=2'b10, d_addr=0x100, memory returns 0xDEADBEEF.
  - mem_en=1, mem_we=0, mem_addr=0x100 one cycle after request.
  - d_ready=1 with d_rdata=0xDEADBEEF 3 cycles after request; stall_mem=1 until then.
- Single store:
  - d_ctrl=2'b01, d_addr=0x200, d_wdata=0x12345678.
  - mem_en=mem_we=1 with those values one cycle later; d_ready 2 cycles after request; i_rdata unchanged.
- Simultaneous i_req and d read:
  - Data served first, then fetch after one IDLE cycle.
  - i_ready arrives 2*(MEM_LAT+2)+1 cycles after the requests; stall_if=1 throughout.
- Fairness, FAIR_LIMIT=4: continuous data reads plus constant i_req -> exactly 4 data grants, then one fetch grant, then data resumes. fair_cnt clears after the fetch grant.
- d_ctrl=2'b11 with MEM_LAT=3 -> performed as a write (mem_we=1); d_ready 2 cycles after request; no read capture.
